// File: rtl/convo_channel_sched.sv
// Channel scheduler for a 3x3 convolution core: accumulates NUM_CH per-channel core results
// into one output pixel per frame step. Optional bias preload is enabled by defining CONVO_BIAS_EN.
module convo_channel_sched #(
    parameter int NUM_CH = 3,
    parameter int CH_W   = 4,
    parameter int PIX_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [PIX_W-1:0] cfg_pix_count,
    output logic             busy,
    output logic             done,
`ifdef CONVO_BIAS_EN
    input  logic [31:0]      bias,
    input  logic             cfg_bias_we,
`endif
    input  logic             win_valid,
    output logic             win_ready,
    output logic [CH_W-1:0]  kernel_sel,
    output logic             core_valid,
    input  logic [31:0]      core_data,
    output logic [31:0]      add_a,
    output logic [31:0]      add_b,
    input  logic [31:0]      add_sum,
    output logic [31:0]      out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [CH_W-1:0]  ch_cnt;
    logic [PIX_W-1:0] pix_rem;
    logic [31:0]      acc;
    logic             accept;
    logic             last_ch;
    logic             first_ch;
    logic             frame_go;
    logic             frame_empty;
    logic             pix_taken;

`ifdef CONVO_BIAS_EN
    logic [31:0]      bias_q;
`endif

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
    // valid never waits on ready; win_ready depends only on state, and out_valid is
    // driven only from HOLD, so a pixel handshake and a window accept can never coincide.
    assign accept      = win_valid && win_ready;
    assign last_ch     = (ch_cnt == CH_W'(NUM_CH - 1));
    assign first_ch    = (ch_cnt == '0);
    assign frame_go    = (state == IDLE) && start && (cfg_pix_count != '0);
    assign frame_empty = (state == IDLE) && start && (cfg_pix_count == '0);
    assign pix_taken   = (state == HOLD) && out_ready;

    assign busy       = (state != IDLE);
    assign win_ready  = (state == RUN);
    assign out_valid  = (state == HOLD);
    assign core_valid = accept;
    assign kernel_sel = ch_cnt;
    assign out_data   = acc;
    assign add_b      = core_data;

`ifdef CONVO_BIAS_EN
    assign add_a = first_ch ? bias_q : acc;
`else
    assign add_a = acc;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (frame_go) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (accept && last_ch) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_nxt = (pix_rem == '0) ? IDLE : RUN;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch_cnt  <= '0;
            pix_rem <= '0;
            acc     <= 32'h0;
            done    <= 1'b0;
        end else begin
            done <= frame_empty || (pix_taken && (pix_rem == '0));
            if (frame_go) begin
                pix_rem <= cfg_pix_count;
                ch_cnt  <= '0;
            end else if (accept) begin
                if (last_ch) begin
                    ch_cnt  <= '0;
                    pix_rem <= pix_rem - PIX_W'(1);
                end else begin
                    ch_cnt <= ch_cnt + CH_W'(1);
                end
            end
            if (accept) begin
`ifdef CONVO_BIAS_EN
                acc <= add_sum;
`else
                // The first channel starts a fresh sum; later channels add through the external adder.
                acc <= first_ch ? core_data : add_sum;
`endif
            end
        end
    end

`ifdef CONVO_BIAS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bias_q <= 32'h0;
        end else if ((state == IDLE) && cfg_bias_we) begin
            bias_q <= bias;
        end
    end
`endif

endmodule

// File: tb/tb_convo_channel_sched.sv
// Bench for convo_channel_sched: directed frame scenarios plus randomized frames checked
// against a floating-point sum model; a second NUM_CH=1 instance covers the single-channel path.
module tb_convo_channel_sched;

    localparam int NUM_CH = 3;
    localparam int CH_W   = 4;
    localparam int PIX_W  = 16;

    logic             clk;
    logic             rst;
    logic             start;
    logic [PIX_W-1:0] cfg_pix_count;
    logic             busy;
    logic             done;
    logic             win_valid;
    logic             win_ready;
    logic [CH_W-1:0]  kernel_sel;
    logic             core_valid;
    logic [31:0]      core_data;
    logic [31:0]      add_a;
    logic [31:0]      add_b;
    logic [31:0]      add_sum;
    logic [31:0]      out_data;
    logic             out_valid;
    logic             out_ready;

    logic             s1_start;
    logic [PIX_W-1:0] s1_cfg_pix_count;
    logic             s1_busy;
    logic             s1_done;
    logic             s1_win_valid;
    logic             s1_win_ready;
    logic [CH_W-1:0]  s1_kernel_sel;
    logic             s1_core_valid;
    logic [31:0]      s1_core_data;
    logic [31:0]      s1_add_a;
    logic [31:0]      s1_add_b;
    logic [31:0]      s1_add_sum;
    logic [31:0]      s1_out_data;
    logic             s1_out_valid;
    logic             s1_out_ready;

`ifdef CONVO_BIAS_EN
    logic [31:0]      bias;
    logic             cfg_bias_we;
    logic [31:0]      s1_bias;
    logic             s1_cfg_bias_we;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;
    logic [31:0] exp_q[$];

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    always @(negedge clk) begin
        if (done) done_cnt++;
    end

    // ---------------- float helpers (binary32 <-> real) ----------------
    function automatic logic [31:0] to_sp(input real r);
        logic [63:0] d;
        d = $realtobits(r);
        if (d[62:0] == 63'h0) return {d[63], 31'h0};
        return {d[63], 8'(int'(d[62:52]) - 1023 + 127), d[51:29]};
    endfunction

    function automatic real from_sp(input logic [31:0] s);
        logic [63:0] d;
        if (s[30:0] == 31'h0) return 0.0;
        d = {s[31], 11'(int'(s[30:23]) - 127 + 1023), s[22:0], 29'h0};
        return $bitstoreal(d);
    endfunction

    // External combinational FP adders
    assign add_sum    = to_sp(from_sp(add_a) + from_sp(add_b));
    assign s1_add_sum = to_sp(from_sp(s1_add_a) + from_sp(s1_add_b));

    // ---------------- DUTs ----------------
    convo_channel_sched #(.NUM_CH(NUM_CH), .CH_W(CH_W), .PIX_W(PIX_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .cfg_pix_count (cfg_pix_count),
        .busy          (busy),
        .done          (done),
`ifdef CONVO_BIAS_EN
        .bias          (bias),
        .cfg_bias_we   (cfg_bias_we),
`endif
        .win_valid     (win_valid),
        .win_ready     (win_ready),
        .kernel_sel    (kernel_sel),
        .core_valid    (core_valid),
        .core_data     (core_data),
        .add_a         (add_a),
        .add_b         (add_b),
        .add_sum       (add_sum),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready)
    );

    convo_channel_sched #(.NUM_CH(1), .CH_W(CH_W), .PIX_W(PIX_W)) dut1 (
        .clk           (clk),
        .rst           (rst),
        .start         (s1_start),
        .cfg_pix_count (s1_cfg_pix_count),
        .busy          (s1_busy),
        .done          (s1_done),
`ifdef CONVO_BIAS_EN
        .bias          (s1_bias),
        .cfg_bias_we   (s1_cfg_bias_we),
`endif
        .win_valid     (s1_win_valid),
        .win_ready     (s1_win_ready),
        .kernel_sel    (s1_kernel_sel),
        .core_valid    (s1_core_valid),
        .core_data     (s1_core_data),
        .add_a         (s1_add_a),
        .add_b         (s1_add_b),
        .add_sum       (s1_add_sum),
        .out_data      (s1_out_data),
        .out_valid     (s1_out_valid),
        .out_ready     (s1_out_ready)
    );

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- drivers (all start and end at posedge + 1) ----------------
    task automatic start_frame(input logic [PIX_W-1:0] n);
        start = 1'b1;
        cfg_pix_count = n;
        @(posedge clk); #1;
        start = 1'b0;
        cfg_pix_count = PIX_W'($urandom);
    endtask

    task automatic send_win(input logic [31:0] d, input int exp_ch);
        int n;
        n = 0;
        win_valid = 1'b1;
        core_data = d;
        @(negedge clk);
        while (!win_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!win_ready) begin
            check("win_ready_timeout", 32'(win_ready), 1);
        end else begin
            check("kernel_sel", 32'(kernel_sel), exp_ch);
            check("core_valid", 32'(core_valid), 1);
        end
        @(posedge clk); #1;
        win_valid = 1'b0;
        core_data = $urandom;
    endtask

    task automatic recv_pix(input int stall, input bit last);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            check("exp_q_empty", 1, 0);
            e = 32'h0;
        end else begin
            e = exp_q.pop_front();
        end
        @(negedge clk);
        check("out_valid_lat", 32'(out_valid), 1);
        check("out_data", out_data, e);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("hold_out_valid", 32'(out_valid), 1);
            check("hold_win_ready", 32'(win_ready), 0);
            check("hold_out_data", out_data, e);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        win_valid = 1'b1;
        @(negedge clk);
        check("hs_win_ready", 32'(win_ready), 0);
        check("hs_core_valid", 32'(core_valid), 0);
        @(posedge clk); #1;
        out_ready = 1'b0;
        win_valid = 1'b0;
        check("done_after_hs", 32'(done), 32'(last));
        check("busy_after_hs", 32'(busy), 32'(!last));
        if (last) begin
            @(posedge clk); #1;
            check("done_one_cycle", 32'(done), 0);
        end
    endtask

    task automatic do_pixel(input int vals[NUM_CH], input int gap, input int stall, input bit last);
        real s;
        s = 0.0;
        for (int c = 0; c < NUM_CH; c++) s = s + real'(vals[c]);
        exp_q.push_back(to_sp(s));
        for (int c = 0; c < NUM_CH; c++) begin
            send_win(to_sp(real'(vals[c])), c);
            if (c != NUM_CH - 1) begin
                for (int g = 0; g < gap; g++) begin
                    @(negedge clk);
                    check("gap_core_valid", 32'(core_valid), 0);
                    check("gap_kernel_sel", 32'(kernel_sel), c + 1);
                    @(posedge clk); #1;
                end
            end
        end
        recv_pix(stall, last);
    endtask

    task automatic rand_pixel(input bit last);
        int vals[NUM_CH];
        for (int c = 0; c < NUM_CH; c++) vals[c] = $urandom_range(0, 50);
        do_pixel(vals, $urandom_range(0, 2), $urandom_range(0, 3), last);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int vals[NUM_CH];
        int n_pix;
        int dc;
        logic [31:0] s1_exp;

        rst = 1'b1;
        start = 1'b0;
        cfg_pix_count = '0;
        win_valid = 1'b1;
        core_data = 32'h0;
        out_ready = 1'b0;
        s1_start = 1'b0;
        s1_cfg_pix_count = '0;
        s1_win_valid = 1'b0;
        s1_core_data = 32'h0;
        s1_out_ready = 1'b0;
`ifdef CONVO_BIAS_EN
        bias = 32'h0;
        cfg_bias_we = 1'b0;
        s1_bias = 32'h0;
        s1_cfg_bias_we = 1'b0;
`endif

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_win_ready", 32'(win_ready), 0);
        check("rst_core_valid", 32'(core_valid), 0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_kernel_sel", 32'(kernel_sel), 0);
        check("rst_out_data", out_data, 0);
        @(posedge clk); #1;
        win_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;

        // 1.0 + 2.0 + 3.0 = 6.0, single pixel
        start_frame(1);
        vals = '{1, 2, 3};
        do_pixel(vals, 0, 0, 1'b1);
        check("sum_6_bits", to_sp(6.0), 32'h40C00000);

        // Two pixels, gaps of 2, output stalled 5 cycles
        start_frame(2);
        vals = '{4, 5, 6};
        do_pixel(vals, 2, 5, 1'b0);
        vals = '{10, 20, 7};
        do_pixel(vals, 2, 5, 1'b1);

        // Empty frame
        dc = done_cnt;
        start = 1'b1;
        cfg_pix_count = '0;
        @(negedge clk);
        check("empty_busy_pre", 32'(busy), 0);
        check("empty_done_pre", 32'(done), 0);
        @(posedge clk); #1;
        start = 1'b0;
        check("empty_done", 32'(done), 1);
        check("empty_busy", 32'(busy), 0);
        @(posedge clk); #1;
        check("empty_done_off", 32'(done), 0);
        check("empty_busy_off", 32'(busy), 0);
        check("empty_done_cnt", done_cnt - dc, 1);

        // Reset after the second channel accept
        start_frame(1);
        send_win(to_sp(9.0), 0);
        send_win(to_sp(8.0), 1);
        win_valid = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check("mrst_busy", 32'(busy), 0);
        check("mrst_win_ready", 32'(win_ready), 0);
        check("mrst_core_valid", 32'(core_valid), 0);
        check("mrst_out_valid", 32'(out_valid), 0);
        check("mrst_kernel_sel", 32'(kernel_sel), 0);
        check("mrst_out_data", out_data, 0);
        check("mrst_done", 32'(done), 0);
        dc = done_cnt;
        @(posedge clk); #1;
        win_valid = 1'b0;
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("mrst_no_done", done_cnt - dc, 0);
        check("mrst_idle", 32'(busy), 0);
        start_frame(1);
        vals = '{11, 12, 13};
        do_pixel(vals, 1, 1, 1'b1);

        // start held through the first pixel of a 2-pixel frame with another count
        start_frame(2);
        start = 1'b1;
        cfg_pix_count = 7;
        rand_pixel(1'b0);
        start = 1'b0;
        rand_pixel(1'b1);

        // Randomized frames
        for (int f = 0; f < 6; f++) begin
            n_pix = $urandom_range(1, 3);
            start_frame(PIX_W'(n_pix));
            for (int p = 0; p < n_pix; p++) rand_pixel(p == n_pix - 1);
        end

        // Single-channel instance
`ifdef CONVO_BIAS_EN
        s1_bias = to_sp(0.5);
        s1_cfg_bias_we = 1'b1;
        @(posedge clk); #1;
        s1_cfg_bias_we = 1'b0;
        s1_exp = 32'h40000000;
`else
        s1_exp = 32'h3FC00000;
`endif
        s1_start = 1'b1;
        s1_cfg_pix_count = 1;
        @(posedge clk); #1;
        s1_start = 1'b0;
        s1_win_valid = 1'b1;
        s1_core_data = to_sp(1.5);
        @(negedge clk);
        check("s1_win_ready", 32'(s1_win_ready), 1);
        check("s1_kernel_sel", 32'(s1_kernel_sel), 0);
        @(posedge clk); #1;
        s1_win_valid = 1'b0;
        @(negedge clk);
        check("s1_out_valid", 32'(s1_out_valid), 1);
        check("s1_out_data", s1_out_data, s1_exp);
        @(posedge clk); #1;
        s1_out_ready = 1'b1;
        @(posedge clk); #1;
        s1_out_ready = 1'b0;
        check("s1_done", 32'(s1_done), 1);
        check("s1_busy", 32'(s1_busy), 0);

        check("exp_q_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/convo_channel_sched.md
CONVO_CHANNEL_SCHED -- requirements
Module: convo_channel_sched

Interface
REQ-001 SHALL have parameter NUM_CH, default 3: number of input channels accumulated per output pixel (legal range 1..15).
REQ-002 SHALL have parameter CH_W, default 4: width of the channel index; 2^CH_W SHALL be greater than NUM_CH.
REQ-003 SHALL have parameter PIX_W, default 16: width of the pixel counter.
REQ-004 SHALL have one clock and one reset: clk is the single clock; rst is asynchronous and active-high.
REQ-005 SHALL have ports (name, direction, width, meaning):
- clk  in  1  clock
- rst  in  1  async active-high reset
- start  in  1  begin frame, sampled in IDLE only
- cfg_pix_count  in  PIX_W  output pixels in the frame, latched on start
- busy  out  1  high outside IDLE
- done  out  1  one-cycle pulse at end of frame
- win_valid  in  1  a 3x3 window plus kernel set is presented to the conv core
- win_ready  out  1  scheduler accepts the window
- kernel_sel  out  CH_W  channel index; selects the kernel bank feeding the core
- core_valid  out  1  equals win_valid AND win_ready; drives the core Valid_In
- core_data  in  32  core Data_Out (IEEE-754 single)
- add_a  out  32  operand A of the external FP adder
- add_b  out  32  operand B of the external FP adder (= core_data)
- add_sum  in  32  combinational result from the external FP adder
- out_data  out  32  accumulated pixel value
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts out_data

Function
REQ-006 FSM SHALL have states IDLE, RUN, HOLD.
REQ-007 IDLE: win_ready=0, out_valid=0, busy=0.
- start=1 with cfg_pix_count>0: latch the count into pix_rem, ch_cnt=0, go to RUN.
- start=1 with cfg_pix_count=0: pulse done on the next cycle and stay in IDLE.
REQ-008 RUN: win_ready=1 and kernel_sel=ch_cnt. Each accepted window (win_valid AND win_ready) SHALL update acc in that same clock edge and increment ch_cnt.
REQ-009 Accumulation on an accepted window:
- ch_cnt=0: acc <= core_data. With CONVO_BIAS_EN defined, this case follows REQ-018 instead.
- ch_cnt>0: acc <= add_sum, where add_a=acc and add_b=core_data.
REQ-010 Accepting the window with ch_cnt=NUM_CH-1 SHALL:
- reset ch_cnt to 0;
- decrement pix_rem;
- go to HOLD.
out_valid SHALL be asserted in the cycle after the last channel is accepted (latency 1 cycle).
REQ-011 HOLD: out_valid=1, out_data=acc held stable, win_ready=0.
- On out_ready=1 with pix_rem>0: go to RUN.
- On out_ready=1 with pix_rem=0: go to IDLE and pulse done in that same transition cycle (done registered, high for exactly one cycle).
REQ-012 No window SHALL be accepted in the cycle out_valid and out_ready are both high. The next window is accepted no earlier than the following cycle.
REQ-013 win_valid deasserting in RUN between channels SHALL stall with no change to acc or ch_cnt. Gaps of any length SHALL be legal.
REQ-014 start asserted outside IDLE SHALL be ignored. cfg_pix_count SHALL only be sampled in IDLE.
REQ-015 With NUM_CH=1, every accepted window SHALL go directly to HOLD, with acc = core_data (or bias-added per REQ-018).

Reset
REQ-016 While rst=1, regardless of clk, the block SHALL hold:
- state=IDLE, ch_cnt=0, pix_rem=0, acc=32'h0;
- done=0, out_valid=0, win_ready=0, busy=0, core_valid=0, kernel_sel=0.
REQ-017 Asserting rst mid-frame SHALL abandon the partial accumulation and produce no done pulse. Operation SHALL resume only on a new start after rst deasserts.

Configuration
REQ-018 Macro CONVO_BIAS_EN defined:
- add input port bias (32) and input cfg_bias_we (1).
- cfg_bias_we=1 in IDLE loads bias into an internal bias register (reset value 0).
- at ch_cnt=0: add_a = bias register, add_b = core_data, acc <= add_sum.
REQ-019 Macro CONVO_BIAS_EN undefined: the bias ports and register SHALL not exist, and ch_cnt=0 behaviour SHALL be exactly as REQ-009.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- NUM_CH=3, cfg_pix_count=1, core_data 1.0, 2.0, 3.0 (adder model) -> out_valid one cycle after the third accept, out_data=32'h40C00000 (6.0); done pulses on out_ready.
- cfg_pix_count=2, win_valid gaps of 2 cycles between channels, out_ready held low 5 cycles in HOLD -> win_ready=0 and out_data stable throughout; the second pixel starts only after the handshake; kernel_sel sequence 0,1,2,0,1,2.
- start with cfg_pix_count=0 -> done high exactly one cycle after start; busy never high.
- rst asserted after the second channel accept -> all outputs 0 immediately; no done; a new frame then yields correct sums.
- start pulsed during RUN with a different cfg_pix_count -> ignored; frame length unchanged.
- CONVO_BIAS_EN with bias 0.5 and NUM_CH=1, core_data 1.5 -> out_data=32'h40000000 (2.0).
